// File: rtl/dac_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// dac_sweep_sequencer
//
// Purpose: steps a DAC through cyclic-voltammetry style triangular sweeps
// (init -> v1 -> v2 -> init, repeated cfg_cycles times). Each sweep point is
// handed to a DAC serializer with a one-cycle load strobe and then held for
// a programmable number of clocks. An abort parks the DAC back at the
// starting potential.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start        one-cycle sweep request (accepted only when idle)
//   abort        level, terminates a running sweep via a park load
//   cfg_init     start/end potential code
//   cfg_v1       first vertex code
//   cfg_v2       second vertex code
//   cfg_step     step magnitude per point (0 behaves as 1)
//   cfg_period   clocks per point (clamped up to MIN_PERIOD)
//   cfg_cycles   number of full triangle cycles (0 behaves as 1)
//   dac_busy     serializer is shifting; no load while high
//   dac_code     code presented to the serializer
//   dac_load     one-cycle load strobe
//   busy         sweep in progress
//   step_tick    ADC trigger, coincident with each sweep-point load
//   seg          current segment: 0 toward v1, 1 toward v2, 2 toward init
//   done         one-cycle pulse on normal completion
//   aborted      one-cycle pulse on abort completion
// ---------------------------------------------------------------------------
module dac_sweep_sequencer #(
  parameter int MIN_PERIOD = 32,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_init,
  input  logic [DW-1:0] cfg_v1,
  input  logic [DW-1:0] cfg_v2,
  input  logic [DW-1:0] cfg_step,
  input  logic [23:0]   cfg_period,
  input  logic [7:0]    cfg_cycles,
  input  logic          dac_busy,
  output logic [DW-1:0] dac_code,
  output logic          dac_load,
  output logic          busy,
  output logic          step_tick,
  output logic [1:0]    seg,
  output logic          done,
  output logic          aborted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_PARK   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [23:0] MIN_P = 24'(MIN_PERIOD);

  logic [2:0]    state;
  logic [DW-1:0] cur;
  logic [DW-1:0] code_q;
  logic [7:0]    cycle_cnt;
  logic [23:0]   hold_cnt;

  logic [DW-1:0] lat_init;
  logic [DW-1:0] lat_v1;
  logic [DW-1:0] lat_v2;
  logic [DW-1:0] lat_step;
  logic [23:0]   lat_period;
  logic [7:0]    lat_cycles;

  logic          issue_fire;
  logic          park_fire;

  logic [1:0]    adv_seg;
  logic [7:0]    adv_cyc;
  logic          adv_fin;
  logic          adv_found;
  logic [DW-1:0] adv_next;
  logic [DW-1:0] tgt;
  logic [DW:0]   up_sum;
  logic [DW:0]   dn_diff;

  // Abort has priority over a pending point load, so an aborting ISSUE never
  // emits a sweep point.
  assign issue_fire = (state == S_ISSUE) && !dac_busy && !abort;
  assign park_fire  = (state == S_PARK) && !dac_busy;

  assign dac_load  = issue_fire | park_fire;
  assign step_tick = issue_fire;
  assign aborted   = park_fire;
  assign done      = (state == S_FINISH) && !abort;
  assign busy      = (state != S_IDLE);

  // The code is driven early while waiting for the serializer; code_q keeps
  // the last loaded value visible once idle.
  always_comb begin
    if (state == S_ISSUE)
      dac_code = cur;
    else if (state == S_PARK)
      dac_code = lat_init;
    else
      dac_code = code_q;
  end

  // Next-point computation. Segments whose target already equals cur are
  // skipped in the same cycle; two full laps of the three segments without
  // finding a move can only mean init==v1==v2, which finishes the sweep.
  // Sums are formed at DW+1 bits so overflow/underflow clamps to the target.
  always_comb begin
    adv_seg   = seg;
    adv_cyc   = cycle_cnt;
    adv_fin   = 1'b0;
    adv_found = 1'b0;
    adv_next  = cur;
    tgt       = lat_init;
    up_sum    = '0;
    dn_diff   = '0;
    for (int i = 0; i < 6; i++) begin
      if (!adv_found && !adv_fin) begin
        case (adv_seg)
          2'd0:    tgt = lat_v1;
          2'd1:    tgt = lat_v2;
          default: tgt = lat_init;
        endcase
        if (tgt == cur) begin
          if (adv_seg == 2'd2) begin
            adv_seg = 2'd0;
            if (({1'b0, adv_cyc} + 9'd1) >= {1'b0, lat_cycles})
              adv_fin = 1'b1;
            else
              adv_cyc = adv_cyc + 8'd1;
          end else begin
            adv_seg = adv_seg + 2'd1;
          end
        end else begin
          adv_found = 1'b1;
          if (tgt > cur) begin
            up_sum   = {1'b0, cur} + {1'b0, lat_step};
            adv_next = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DW-1:0];
          end else begin
            dn_diff  = {1'b0, cur} - {1'b0, lat_step};
            adv_next = (dn_diff[DW] || (dn_diff <= {1'b0, tgt})) ? tgt : dn_diff[DW-1:0];
          end
        end
      end
    end
    if (!adv_found)
      adv_fin = 1'b1;
  end

  // hold_cnt starts at 1 on the load cycle itself, so leaving HOLD when it
  // reaches period-1 puts the next load exactly period clocks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      code_q     <= '0;
      seg        <= 2'd0;
      cycle_cnt  <= 8'd0;
      hold_cnt   <= 24'd0;
      lat_init   <= '0;
      lat_v1     <= '0;
      lat_v2     <= '0;
      lat_step   <= '0;
      lat_period <= 24'd0;
      lat_cycles <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            lat_init   <= cfg_init;
            lat_v1     <= cfg_v1;
            lat_v2     <= cfg_v2;
            lat_step   <= (cfg_step == '0) ? {{(DW-1){1'b0}}, 1'b1} : cfg_step;
            lat_period <= (cfg_period < MIN_P) ? MIN_P : cfg_period;
            lat_cycles <= (cfg_cycles == 8'd0) ? 8'd1 : cfg_cycles;
            cur        <= cfg_init;
            seg        <= 2'd0;
            cycle_cnt  <= 8'd0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state <= S_PARK;
          end else if (!dac_busy) begin
            code_q   <= cur;
            hold_cnt <= 24'd1;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort) begin
            state <= S_PARK;
          end else if (hold_cnt >= (lat_period - 24'd1)) begin
            if (adv_fin) begin
              state <= S_FINISH;
            end else begin
              cur       <= adv_next;
              seg       <= adv_seg;
              cycle_cnt <= adv_cyc;
              state     <= S_ISSUE;
            end
          end else begin
            hold_cnt <= hold_cnt + 24'd1;
          end
        end
        S_PARK: begin
          if (!dac_busy) begin
            code_q <= lat_init;
            state  <= S_IDLE;
          end
        end
        S_FINISH: begin
          state <= abort ? S_PARK : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dac_sweep_sequencer.md
DAC_SWEEP_SEQUENCER -- requirements
Module: dac_sweep_sequencer

Interface
REQ-001 SHALL have parameter MIN_PERIOD, default 32, minimum clocks per sweep point; must exceed one DAC serializer frame of 27 clocks.
REQ-002 SHALL have parameter DW, default 16, DAC code width.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; 0 = reset.
REQ-005 start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 abort  in  1  level; terminates a running sweep.
REQ-007 cfg_init  in  DW  start/end potential code.
REQ-008 cfg_v1  in  DW  first vertex code.
REQ-009 cfg_v2  in  DW  second vertex code.
REQ-010 cfg_step  in  DW  step magnitude per point, unsigned.
REQ-011 cfg_period  in  24  clocks per point.
REQ-012 cfg_cycles  in  8  number of init->v1->v2->init cycles.
REQ-013 dac_busy  in  1  serializer is shifting a frame; high = do not load.
REQ-014 dac_code  out  DW  code presented to the serializer.
REQ-015 dac_load  out  1  one-cycle strobe; dac_code is valid on that cycle.
REQ-016 busy  out  1  high from the cycle after accepted start until return to IDLE.
REQ-017 step_tick  out  1  one-cycle pulse coincident with each dac_load of a sweep point (ADC sampling trigger).
REQ-018 seg  out  2  current segment: 0 = toward v1, 1 = toward v2, 2 = toward init.
REQ-019 done  out  1  one-cycle pulse on normal completion.
REQ-020 aborted  out  1  one-cycle pulse on abort completion.

Function
REQ-021 SHALL implement states IDLE, ISSUE, HOLD, PARK, FINISH.
- IDLE->ISSUE on start.
- ISSUE->HOLD on dac_load.
- HOLD->ISSUE at period end with more points.
- HOLD->FINISH at period end after the last point.
- any state except IDLE->PARK on abort.
- PARK->IDLE on dac_load.
- FINISH->IDLE after 1 cycle.
REQ-022 On accepted start, SHALL latch all cfg_* inputs; later cfg changes have no effect until the next start.
REQ-023 On start, SHALL set cur=init, seg=0, cycle_cnt=0.
REQ-024 SHALL treat latched step=0 as 1, cycles=0 as 1, and period<MIN_PERIOD as MIN_PERIOD.
REQ-025 ISSUE: SHALL assert dac_load and step_tick with dac_code=cur on the first cycle in which dac_busy=0; while dac_busy=1, SHALL wait without limit.
REQ-026 HOLD: SHALL count period clocks beginning with the dac_load cycle; the next dac_load is never earlier than period clocks after the previous one.
REQ-027 Advance: SHALL set the segment target to v1, v2 or init for seg 0, 1 or 2 respectively.
REQ-028 Advance: direction is up if target>cur, else down; next=cur±step, computed at DW+1 bits.
REQ-029 Advance: next SHALL clamp to target if it passes the target or leaves 0..2^DW-1; no wrap-around.
REQ-030 When cur equals the target, SHALL increment seg; seg 2->0 SHALL increment cycle_cnt.
REQ-031 Zero-length segments (target==cur) SHALL be skipped in the same advance cycle, producing no extra point.
REQ-032 The last point is init at the end of seg 2 of the final cycle; after its hold, SHALL pulse done in FINISH.
REQ-033 If init==v1==v2, SHALL issue exactly one point, then done.
REQ-034 Point count per cycle with no clamping is |v1-init|/step + |v2-v1|/step + |init-v2|/step; the first cycle adds one for the initial point.
REQ-035 abort SHALL go to PARK: wait for dac_busy=0, load dac_code=latched init with dac_load, no step_tick, pulse aborted, then IDLE.
REQ-036 start coincident with abort in IDLE SHALL be ignored.
REQ-037 start while busy SHALL be ignored.
REQ-038 dac_code SHALL hold its last value in IDLE.

Reset
REQ-039 rst=0 SHALL asynchronously force IDLE, dac_code=0, dac_load=0, step_tick=0, busy=0, seg=0, done=0, aborted=0, and clear all counters and latched configuration.
REQ-040 Reset mid-sweep SHALL abandon the sweep with no park load; the first start after rst=1 behaves as from power-up.

Verification
REQ-041 init=100, v1=110, v2=90, step=5, period=40, cycles=1, dac_busy=0 -> codes 100,105,110,105,100,95,90,95,100; loads 40 clocks apart; done 40 clocks after last load.
REQ-042 init=0, v1=7, v2=0, step=3 -> codes 0,3,6,7,4,1,0 (clamp on both vertices).
REQ-043 cfg_period=5 -> loads spaced 32 clocks; dac_busy held high 50 clocks at one ISSUE -> load delayed until dac_busy falls, spacing grows accordingly.
REQ-044 abort during the 3rd point's HOLD while dac_busy=1 -> park load of init after dac_busy falls, aborted pulse, no done, busy low next cycle.
REQ-045 init=v1=v2=500 -> single load of 500, done after period; start pulsed while busy -> ignored.
REQ-046 rst=0 mid-HOLD -> all outputs reset within the same cycle; new start afterwards gives a sequence identical to REQ-041.
